// File: rtl/sdram_arbit_if.sv
// Handshake bundle between the SDRAM command arbiter and its surroundings:
// requesters, the init sequencer and the refresh/write/read sub-FSMs.
interface sdram_arbit_if;
  logic init_done;
  logic wr_req;
  logic rd_req;
  logic ref_end;
  logic wr_end;
  logic rd_end;
  logic ref_en;
  logic wr_en;
  logic rd_en;
  logic wr_ack;
  logic rd_ack;
  logic busy;
  logic ref_miss;

  // System side: drives requests and done pulses, observes grants.
  modport master (
    output init_done, wr_req, rd_req, ref_end, wr_end, rd_end,
    input  ref_en, wr_en, rd_en, wr_ack, rd_ack, busy, ref_miss
  );

  // Arbiter side.
  modport slave (
    input  init_done, wr_req, rd_req, ref_end, wr_end, rd_end,
    output ref_en, wr_en, rd_en, wr_ack, rd_ack, busy, ref_miss
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: sequences refresh, write and read operations.
// Refresh has absolute priority at the IDLE decision point; competing
// write/read requests are served round-robin. Operations run to completion
// and always return through IDLE before the next grant.
module sdram_arbit #(
  parameter int REF_CYC = 780,  // refresh interval in clk cycles
  parameter int CNT_W   = 10    // timer width, 2**CNT_W must exceed REF_CYC
) (
  input  logic          clk,
  input  logic          rst,
  sdram_arbit_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_REF,
    ST_WR,
    ST_RD
  } state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(REF_CYC - 1);

  state_t           state;
  grant_t           last_grant;
  logic [CNT_W-1:0] timer;
  logic             ref_due;
  logic             wrap;
  logic             go_ref;
  logic             go_wr;
  logic             go_rd;

  // Enables decode straight from the state register, so they are mutually
  // exclusive and fall together with the state on an asynchronous reset.
  assign bus.ref_en = (state == ST_REF);
  assign bus.wr_en  = (state == ST_WR);
  assign bus.rd_en  = (state == ST_RD);

  // Timer wrap detection and the IDLE grant decision.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if/else chain can leave it unassigned (no latch).
    wrap   = 1'b0;
    go_ref = 1'b0;
    go_wr  = 1'b0;
    go_rd  = 1'b0;
    if (state != ST_INIT && timer == TIMER_LAST) begin
      wrap = 1'b1;
    end
    if (state == ST_IDLE && bus.init_done) begin
      if (ref_due) begin
        go_ref = 1'b1;
      end else if (bus.wr_req && bus.rd_req) begin
        // Both pending: serve whoever was not granted last.
        if (last_grant == GNT_RD) go_wr = 1'b1;
        else                      go_rd = 1'b1;
      end else if (bus.wr_req) begin
        go_wr = 1'b1;
      end else if (bus.rd_req) begin
        go_rd = 1'b1;
      end
    end
  end

  // Refresh interval timer, pending-refresh flag and sticky overrun flag.
  // NOTE: asynchronous reset lives in the sensitivity list; state registers
  // are assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer        <= '0;
      ref_due      <= 1'b0;
      bus.ref_miss <= 1'b0;
    end else if (!bus.init_done) begin
      timer   <= '0;
      ref_due <= 1'b0;
    end else if (state == ST_INIT) begin
      timer <= '0;
    end else begin
      timer <= wrap ? '0 : timer + CNT_W'(1);
      if (wrap) begin
        // A new interval beats the clear on REF entry, so back-to-back
        // deadlines are never lost.
        ref_due <= 1'b1;
        if (ref_due && !go_ref) begin
          bus.ref_miss <= 1'b1;
        end
      end else if (go_ref) begin
        ref_due <= 1'b0;
      end
    end
  end

  // Main sequencer: state, registered grant pulses, busy and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      last_grant <= GNT_RD;
      bus.wr_ack <= 1'b0;
      bus.rd_ack <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      bus.wr_ack <= 1'b0;
      bus.rd_ack <= 1'b0;
      if (!bus.init_done) begin
        state    <= ST_INIT;
        bus.busy <= 1'b1;
      end else begin
        unique case (state)
          ST_INIT: begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
          ST_IDLE: begin
            if (go_ref) begin
              state    <= ST_REF;
              bus.busy <= 1'b1;
            end else if (go_wr) begin
              state      <= ST_WR;
              last_grant <= GNT_WR;
              bus.wr_ack <= 1'b1;
              bus.busy   <= 1'b1;
            end else if (go_rd) begin
              state      <= ST_RD;
              last_grant <= GNT_RD;
              bus.rd_ack <= 1'b1;
              bus.busy   <= 1'b1;
            end
          end
          ST_REF: begin
            if (bus.ref_end) begin
              state    <= ST_IDLE;
              bus.busy <= 1'b0;
            end
          end
          ST_WR: begin
            if (bus.wr_end) begin
              state    <= ST_IDLE;
              bus.busy <= 1'b0;
            end
          end
          ST_RD: begin
            if (bus.rd_end) begin
              state    <= ST_IDLE;
              bus.busy <= 1'b0;
            end
          end
          default: begin
            state    <= ST_INIT;
            bus.busy <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit with a 20-cycle refresh interval.
// Edge numbering: E1 is the first rising edge after rst is released.
module tb_sdram_arbit;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  sdram_arbit_if arb_bus ();

  sdram_arbit #(
    .REF_CYC (20),
    .CNT_W   (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_bus.slave)
  );

  // Observation vector bit positions.
  localparam logic [6:0] O_REF  = 7'b1000000;
  localparam logic [6:0] O_WR   = 7'b0100000;
  localparam logic [6:0] O_RD   = 7'b0010000;
  localparam logic [6:0] O_WACK = 7'b0001000;
  localparam logic [6:0] O_RACK = 7'b0000100;
  localparam logic [6:0] O_BUSY = 7'b0000010;
  localparam logic [6:0] O_MISS = 7'b0000001;
  localparam logic [6:0] O_NONE = 7'b0000000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {arb_bus.ref_en, arb_bus.wr_en, arb_bus.rd_en, arb_bus.wr_ack,
            arb_bus.rd_ack, arb_bus.busy, arb_bus.ref_miss};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    arb_bus.wr_req  = 1'b0;
    arb_bus.rd_req  = 1'b0;
    arb_bus.ref_end = 1'b0;
    arb_bus.wr_end  = 1'b0;
    arb_bus.rd_end  = 1'b0;
  endtask

  task automatic do_reset(input logic init);
    rst = 1'b1;
    clear_inputs();
    arb_bus.init_done = init;
    tick_n(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    arb_bus.init_done = 1'b0;
    tick();
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want %b", obs(), O_NONE);
    end
    arb_bus.init_done = 1'b1;
    arb_bus.wr_req = 1'b1;
    tick();
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL reset_dominates: got %b want %b", obs(), O_NONE);
    end
    rst = 1'b0;
    arb_bus.init_done = 1'b0;
    tick_n(2);
    vectors++;
    if (obs() !== O_BUSY) begin
      miscompares++;
      $display("FAIL init_no_grant: got %b want %b", obs(), O_BUSY);
    end
    arb_bus.init_done = 1'b1;
    tick();
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL init_to_idle: got %b want %b", obs(), O_NONE);
    end
    tick();
    vectors++;
    if (obs() !== (O_WR | O_WACK | O_BUSY)) begin
      miscompares++;
      $display("FAIL first_grant_after_init: got %b want %b", obs(), O_WR | O_WACK | O_BUSY);
    end
    arb_bus.wr_req = 1'b0;
    arb_bus.wr_end = 1'b1;
    tick();
    arb_bus.wr_end = 1'b0;
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL reset_test_end: got %b want %b", obs(), O_NONE);
    end
  endtask

  task automatic test_write();
    do_reset(1'b1);
    arb_bus.wr_req = 1'b1;
    tick();  // E1
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL wr_idle_first: got %b want %b", obs(), O_NONE);
    end
    tick();  // E2
    vectors++;
    if (obs() !== (O_WR | O_WACK | O_BUSY)) begin
      miscompares++;
      $display("FAIL wr_grant: got %b want %b", obs(), O_WR | O_WACK | O_BUSY);
    end
    tick();  // E3
    vectors++;
    if (obs() !== (O_WR | O_BUSY)) begin
      miscompares++;
      $display("FAIL wr_ack_one_cycle: got %b want %b", obs(), O_WR | O_BUSY);
    end
    // Stray end pulses and a short-lived read request while WR is active.
    arb_bus.rd_end  = 1'b1;
    arb_bus.ref_end = 1'b1;
    arb_bus.rd_req  = 1'b1;
    tick();  // E4
    arb_bus.rd_end  = 1'b0;
    arb_bus.ref_end = 1'b0;
    arb_bus.rd_req  = 1'b0;
    vectors++;
    if (obs() !== (O_WR | O_BUSY)) begin
      miscompares++;
      $display("FAIL wr_ignores_other_ends: got %b want %b", obs(), O_WR | O_BUSY);
    end
    arb_bus.wr_end = 1'b1;
    tick();  // E5
    arb_bus.wr_end = 1'b0;
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL wr_end_idle_gap: got %b want %b", obs(), O_NONE);
    end
    tick();  // E6: wr_req still held, dropped rd_req not served
    vectors++;
    if (obs() !== (O_WR | O_WACK | O_BUSY)) begin
      miscompares++;
      $display("FAIL wr_held_regrant: got %b want %b", obs(), O_WR | O_WACK | O_BUSY);
    end
    arb_bus.wr_req = 1'b0;
    arb_bus.wr_end = 1'b1;
    tick();  // E7
    arb_bus.wr_end = 1'b0;
    tick();  // E8
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL wr_dropped_no_grant: got %b want %b", obs(), O_NONE);
    end
  endtask

  task automatic test_round_robin();
    logic       got;
    logic [6:0] exp;
    do_reset(1'b1);
    arb_bus.wr_req = 1'b1;
    arb_bus.rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
        tick();
        if (arb_bus.wr_ack || arb_bus.rd_ack) begin
          got = 1'b1;
        end else if (arb_bus.ref_en) begin
          arb_bus.ref_end = 1'b1;
          tick();
          arb_bus.ref_end = 1'b0;
        end
      end
      exp = (g % 2 == 0) ? (O_WR | O_WACK | O_BUSY) : (O_RD | O_RACK | O_BUSY);
      vectors++;
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL rr_grant_%0d: got %b want %b (granted=%b)", g, obs(), exp, got);
      end
      tick_n(9);
      if (g % 2 == 0) arb_bus.wr_end = 1'b1;
      else            arb_bus.rd_end = 1'b1;
      tick();
      arb_bus.wr_end = 1'b0;
      arb_bus.rd_end = 1'b0;
      vectors++;
      if (obs() !== O_NONE) begin
        miscompares++;
        $display("FAIL rr_idle_gap_%0d: got %b want %b", g, obs(), O_NONE);
      end
    end
    clear_inputs();
  endtask

  task automatic test_refresh();
    int   nrise;
    int   rise_at;
    logic prev;
    do_reset(1'b1);
    nrise   = 0;
    rise_at = -100;
    prev    = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      arb_bus.ref_end = 1'b0;
      if (arb_bus.ref_en && !prev) begin
        vectors++;
        if (k != 22 + 20 * nrise) begin
          miscompares++;
          $display("FAIL ref_rise_%0d: got edge %0d want edge %0d", nrise, k, 22 + 20 * nrise);
        end
        rise_at = k;
        nrise++;
      end
      if (k == rise_at + 5) begin
        vectors++;
        if (arb_bus.ref_en !== 1'b0) begin
          miscompares++;
          $display("FAIL ref_end_release_%0d: got ref_en=%b want 0", nrise, arb_bus.ref_en);
        end
      end
      if (arb_bus.ref_en && k == rise_at + 4) arb_bus.ref_end = 1'b1;
      prev = arb_bus.ref_en;
    end
    vectors++;
    if (nrise != 3) begin
      miscompares++;
      $display("FAIL ref_count: got %0d want 3", nrise);
    end
    vectors++;
    if (arb_bus.ref_miss !== 1'b0) begin
      miscompares++;
      $display("FAIL ref_no_miss: got %b want 0", arb_bus.ref_miss);
    end
  endtask

  task automatic test_ref_miss();
    do_reset(1'b1);
    arb_bus.wr_req = 1'b1;
    tick_n(2);  // E2
    vectors++;
    if (obs() !== (O_WR | O_WACK | O_BUSY)) begin
      miscompares++;
      $display("FAIL miss_wr_grant: got %b want %b", obs(), O_WR | O_WACK | O_BUSY);
    end
    arb_bus.wr_req = 1'b0;
    arb_bus.rd_req = 1'b1;
    tick_n(38);  // E40
    vectors++;
    if (obs() !== (O_WR | O_BUSY)) begin
      miscompares++;
      $display("FAIL miss_before_wrap: got %b want %b", obs(), O_WR | O_BUSY);
    end
    tick();  // E41: second wrap with refresh still pending
    vectors++;
    if (obs() !== (O_WR | O_BUSY | O_MISS)) begin
      miscompares++;
      $display("FAIL miss_set: got %b want %b", obs(), O_WR | O_BUSY | O_MISS);
    end
    tick_n(10);  // E51
    arb_bus.wr_end = 1'b1;
    tick();  // E52
    arb_bus.wr_end = 1'b0;
    vectors++;
    if (obs() !== O_MISS) begin
      miscompares++;
      $display("FAIL miss_wr_done: got %b want %b", obs(), O_MISS);
    end
    tick();  // E53: refresh beats the pending read
    vectors++;
    if (obs() !== (O_REF | O_BUSY | O_MISS)) begin
      miscompares++;
      $display("FAIL miss_ref_first: got %b want %b", obs(), O_REF | O_BUSY | O_MISS);
    end
    arb_bus.ref_end = 1'b1;
    tick();  // E54
    arb_bus.ref_end = 1'b0;
    tick();  // E55
    vectors++;
    if (obs() !== (O_RD | O_RACK | O_BUSY | O_MISS)) begin
      miscompares++;
      $display("FAIL miss_rd_after_ref: got %b want %b", obs(), O_RD | O_RACK | O_BUSY | O_MISS);
    end
    arb_bus.rd_req = 1'b0;
    arb_bus.rd_end = 1'b1;
    tick();  // E56
    arb_bus.rd_end = 1'b0;
    vectors++;
    if (obs() !== O_MISS) begin
      miscompares++;
      $display("FAIL miss_sticky: got %b want %b", obs(), O_MISS);
    end
  endtask

  task automatic test_wrap_on_ref_entry();
    do_reset(1'b1);
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL miss_cleared_by_rst: got %b want %b", obs(), O_NONE);
    end
    arb_bus.wr_req = 1'b1;
    tick_n(2);  // E2
    arb_bus.wr_req = 1'b0;
    tick_n(37);  // E39
    arb_bus.wr_end = 1'b1;
    tick();  // E40
    arb_bus.wr_end = 1'b0;
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL coinc_idle: got %b want %b", obs(), O_NONE);
    end
    tick();  // E41: REF entry on the wrap edge
    vectors++;
    if (obs() !== (O_REF | O_BUSY)) begin
      miscompares++;
      $display("FAIL coinc_ref1: got %b want %b", obs(), O_REF | O_BUSY);
    end
    tick();  // E42
    arb_bus.ref_end = 1'b1;
    tick();  // E43
    arb_bus.ref_end = 1'b0;
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL coinc_idle_between: got %b want %b", obs(), O_NONE);
    end
    tick();  // E44: ref_due survived, second refresh
    vectors++;
    if (obs() !== (O_REF | O_BUSY)) begin
      miscompares++;
      $display("FAIL coinc_ref2: got %b want %b", obs(), O_REF | O_BUSY);
    end
    arb_bus.ref_end = 1'b1;
    tick();  // E45
    arb_bus.ref_end = 1'b0;
    tick();  // E46
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL coinc_no_third: got %b want %b", obs(), O_NONE);
    end
  endtask

  task automatic test_init_drop_and_rst();
    int acks;
    do_reset(1'b1);
    arb_bus.rd_req = 1'b1;
    tick_n(2);  // E2
    vectors++;
    if (obs() !== (O_RD | O_RACK | O_BUSY)) begin
      miscompares++;
      $display("FAIL drop_rd_grant: got %b want %b", obs(), O_RD | O_RACK | O_BUSY);
    end
    arb_bus.rd_req = 1'b0;
    tick_n(20);  // E22, refresh pending since E21
    arb_bus.init_done = 1'b0;
    tick();  // E23
    vectors++;
    if (obs() !== O_BUSY) begin
      miscompares++;
      $display("FAIL drop_to_init: got %b want %b", obs(), O_BUSY);
    end
    arb_bus.init_done = 1'b1;
    tick();  // E24
    tick();  // E25: pending refresh was discarded
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL drop_clears_due: got %b want %b", obs(), O_NONE);
    end
    tick_n(19);  // E44
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL drop_timer_early: got %b want %b", obs(), O_NONE);
    end
    tick();  // E45
    vectors++;
    if (obs() !== (O_REF | O_BUSY)) begin
      miscompares++;
      $display("FAIL drop_timer_restart: got %b want %b", obs(), O_REF | O_BUSY);
    end
    arb_bus.ref_end = 1'b1;
    tick();  // E46
    arb_bus.ref_end = 1'b0;
    arb_bus.wr_req = 1'b1;
    tick();  // E47
    vectors++;
    if (obs() !== (O_WR | O_WACK | O_BUSY)) begin
      miscompares++;
      $display("FAIL rst_wr_grant: got %b want %b", obs(), O_WR | O_WACK | O_BUSY);
    end
    arb_bus.wr_req = 1'b0;
    tick();  // E48
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (obs() !== O_NONE) begin
      miscompares++;
      $display("FAIL rst_async_drop: got %b want %b", obs(), O_NONE);
    end
    tick();
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (arb_bus.wr_ack || arb_bus.rd_ack || arb_bus.wr_en) acks++;
    end
    vectors++;
    if (acks != 0) begin
      miscompares++;
      $display("FAIL rst_no_ack: got %0d grant cycles want 0", acks);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    arb_bus.init_done = 1'b0;
    clear_inputs();
    test_reset();
    test_write();
    test_round_robin();
    test_refresh();
    test_ref_miss();
    test_wrap_on_ref_entry();
    test_init_drop_and_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have parameter REF_CYC, default 780; refresh interval in clk cycles (7.8 us at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 10; refresh timer width; must satisfy 2^CNT_W > REF_CYC.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  reset: one clock; reset is asynchronous and active-high.
REQ-005 init_done  in  1  SDRAM power-up init complete; level.
REQ-006 wr_req  in  1  write request; held high by requester until wr_ack.
REQ-007 rd_req  in  1  read request; held high by requester until rd_ack.
REQ-008 ref_end, wr_end, rd_end  in  1 each  one-cycle done pulses from the refresh, write and read sub-FSMs.
REQ-009 ref_en, wr_en, rd_en  out  1 each  enable to the sub-FSMs; level while the operation is granted.
REQ-010 wr_ack, rd_ack  out  1 each  one-cycle grant pulses to the requester.
REQ-011 busy  out  1  high whenever the state is not IDLE.
REQ-012 ref_miss  out  1  sticky: a refresh interval expired while the previous refresh was still pending.

Function
REQ-013 States SHALL be INIT, IDLE, REF, WR, RD; the state register is the only source of the *_en outputs.
REQ-014 INIT->IDLE on the first cycle init_done=1; no grants, timer held at 0, in INIT.
REQ-015 Refresh timer SHALL count 0..REF_CYC-1 in every non-INIT state and wrap to 0; the wrap cycle sets ref_due.
REQ-016 ref_due SHALL be cleared on the cycle REF is entered; if wrap coincides with REF entry, set wins (ref_due stays 1).
REQ-017 Wrap with ref_due already 1 and not being cleared SHALL set ref_miss; cleared only by rst.
REQ-018 IDLE priority: ref_due -> REF; else single pending request -> its state; else both pending -> round-robin.
REQ-019 Round-robin: a 1-bit last_grant (reset = read) SHALL select the requester not granted last; updated on each WR/RD entry.
REQ-020 wr_ack / rd_ack SHALL be asserted for exactly the cycle the state register first equals WR / RD (registered, 1 cycle after the IDLE decision edge).
REQ-021 ref_en = (state==REF), wr_en = (state==WR), rd_en = (state==RD); mutually exclusive at all times.
REQ-022 REF->IDLE on ref_end, WR->IDLE on wr_end, RD->IDLE on rd_end; end pulses in any other state SHALL be ignored.
REQ-023 Operations are never pre-empted: a refresh falling due during WR/RD waits for the *_end pulse.
REQ-024 Every operation SHALL return through IDLE, giving at least one idle cycle between grants.
REQ-025 A request deasserted before its ack SHALL be dropped without a grant; a request held after its ack is a new request once IDLE is re-entered.
REQ-026 init_done falling in any state SHALL force INIT on the next edge, drop all *_en, and clear ref_due and the timer.

Reset
REQ-027 On rst: state=INIT, timer=0, ref_due=0, last_grant=read, ref_miss=0; all outputs 0.
REQ-028 rst asserted mid-operation SHALL drop *_en immediately (asynchronously); no ack is issued for the interrupted operation.

Verification
REQ-029 rst, init_done=1, wr_req=1 held -> wr_ack one cycle, wr_en high until wr_end, then busy=0 for at least 1 cycle.
REQ-030 wr_req and rd_req both held, end pulses returned 10 cycles after each grant -> grants alternate WR,RD,WR,RD; the first grant is WR.
REQ-031 REF_CYC=20, no requests, ref_end 5 cycles after each ref_en -> ref_en rises every 20 cycles; ref_miss stays 0.
REQ-032 REF_CYC=20, WR granted with wr_end withheld 50 cycles -> ref_miss=1; REF is entered on the cycle after WR->IDLE, ahead of a pending rd_req.
REQ-033 Timer wrap on the same cycle as REF entry -> ref_due remains 1; a second REF follows immediately after the IDLE cycle.
REQ-034 init_done dropped during RD, then rst mid-WR -> INIT with rd_en=0 on the next edge; wr_en low asynchronously; no further acks.
